// File: rtl/foc_cmd_dispatch.sv
// foc_cmd_dispatch: decodes SPI command frames, holds per-channel PID gains
// and PWM period, queues RUN frames and hands them one at a time to the
// target FOC core with a valid/done handshake and a completion timeout.
//
// state  | meaning
// S_IDLE | no frame in flight; pops the queue head when one is waiting
// S_WAIT | frame issued to core target_q; waiting for its done or timeout
module foc_cmd_dispatch #(
  parameter int D_WIDTH        = 16,
  parameter int N_WORDS        = 5,
  parameter int N_CH           = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk_sys_i,
  input  logic                              rstb_i,
  input  logic                              frm_valid_i,
  input  logic [7:0]                        frm_opcode_i,
  input  logic [N_WORDS*D_WIDTH-1:0]        frm_data_i,
  output logic [N_CH*D_WIDTH-1:0]           kpd_o,
  output logic [N_CH*D_WIDTH-1:0]           kpq_o,
  output logic [N_CH*D_WIDTH-1:0]           kid_o,
  output logic [N_CH*D_WIDTH-1:0]           kiq_o,
  output logic [N_CH*D_WIDTH-1:0]           ptop_o,
  output logic [N_CH-1:0]                   clear_pid_o,
  output logic [N_WORDS*D_WIDTH-1:0]        foc_data_o,
  output logic [N_CH-1:0]                   foc_valid_o,
  input  logic [N_CH-1:0]                   foc_done_i,
  output logic                              ready_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o,
  output logic [2:0]                        status_o
);

  localparam int DW    = N_WORDS * D_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CH_IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] CMD_LOAD  = 4'h0;
  localparam logic [3:0] CMD_CLEAR = 4'h1;
  localparam logic [3:0] CMD_CLRST = 4'h2;
  localparam logic [3:0] CMD_RUN   = 4'hF;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // frame capture stage
  logic             frm_vld_q;
  logic [3:0]       frm_cmd_q;
  logic [3:0]       frm_ch_q;
  logic [DW-1:0]    frm_data_q;

  // per-channel configuration
  logic [D_WIDTH-1:0] kpd_q  [N_CH];
  logic [D_WIDTH-1:0] kpq_q  [N_CH];
  logic [D_WIDTH-1:0] kid_q  [N_CH];
  logic [D_WIDTH-1:0] kiq_q  [N_CH];
  logic [D_WIDTH-1:0] ptop_q [N_CH];
  logic [N_CH-1:0]    clear_pid_q;

  // RUN queue
  logic [DW-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [CH_IW-1:0]   fifo_ch_q   [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               ready_q;

  // dispatcher
  state_t             state_q;
  logic [CH_IW-1:0]   target_q;
  logic [DW-1:0]      foc_data_q;
  logic [N_CH-1:0]    foc_valid_q;
  logic [TW-1:0]      timer_q;
  logic [2:0]         status_q;

  logic             ch_ok, known_cmd;
  logic [CH_IW-1:0] ch_idx;
  logic             is_load, is_clear, is_clrst, is_run;
  logic             push, pop, ovf_evt, bad_evt, tmo_evt, done_tgt;

  // Capture each frame so decode works from registered opcode and data.
  always_ff @(posedge clk_sys_i or negedge rstb_i) begin
    if (!rstb_i) begin
      frm_vld_q  <= 1'b0;
      frm_cmd_q  <= '0;
      frm_ch_q   <= '0;
      frm_data_q <= '0;
    end else begin
      frm_vld_q <= frm_valid_i;
      if (frm_valid_i) begin
        frm_cmd_q  <= frm_opcode_i[7:4];
        frm_ch_q   <= frm_opcode_i[3:0];
        frm_data_q <= frm_data_i;
      end
    end
  end

  // Command decode plus queue and error events for the captured frame.
  always_comb begin
    ch_ok     = ({1'b0, frm_ch_q} < 5'(N_CH));
    ch_idx    = frm_ch_q[CH_IW-1:0];
    known_cmd = (frm_cmd_q == CMD_LOAD) || (frm_cmd_q == CMD_CLEAR) ||
                (frm_cmd_q == CMD_RUN);
    is_load   = frm_vld_q && ch_ok && (frm_cmd_q == CMD_LOAD);
    is_clear  = frm_vld_q && ch_ok && (frm_cmd_q == CMD_CLEAR);
    is_run    = frm_vld_q && ch_ok && (frm_cmd_q == CMD_RUN);
    is_clrst  = frm_vld_q && (frm_cmd_q == CMD_CLRST);
    bad_evt   = frm_vld_q && (frm_cmd_q != CMD_CLRST) && (!ch_ok || !known_cmd);
    push      = is_run && (count_q < CW'(FIFO_DEPTH));
    ovf_evt   = is_run && !(count_q < CW'(FIFO_DEPTH));
    pop       = (state_q == S_IDLE) && (count_q != '0);
    done_tgt  = foc_done_i[target_q];
    tmo_evt   = (state_q == S_WAIT) && !done_tgt && (timer_q == TW'(1));
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Gain/period registers and the one-cycle integrator clear.
  always_ff @(posedge clk_sys_i or negedge rstb_i) begin
    if (!rstb_i) begin
      for (int c = 0; c < N_CH; c++) begin
        kpd_q[c]  <= '0;
        kpq_q[c]  <= '0;
        kid_q[c]  <= '0;
        kiq_q[c]  <= '0;
        ptop_q[c] <= '0;
      end
      clear_pid_q <= '0;
    end else begin
      clear_pid_q <= '0;
      if (is_load) begin
        kpd_q[ch_idx]  <= frm_data_q[4*D_WIDTH +: D_WIDTH];
        kpq_q[ch_idx]  <= frm_data_q[3*D_WIDTH +: D_WIDTH];
        kid_q[ch_idx]  <= frm_data_q[2*D_WIDTH +: D_WIDTH];
        kiq_q[ch_idx]  <= frm_data_q[1*D_WIDTH +: D_WIDTH];
        ptop_q[ch_idx] <= frm_data_q[0 +: D_WIDTH];
      end
      if (is_load || is_clear) clear_pid_q[ch_idx] <= 1'b1;
    end
  end

  // Queue pointers, occupancy and registered ready flag.
  always_ff @(posedge clk_sys_i or negedge rstb_i) begin
    if (!rstb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= frm_data_q;
      fifo_ch_q[wr_ptr_q]   <= ch_idx;
    end
  end

  // Dispatcher: issue queue head, then wait for its core's done or timeout.
  always_ff @(posedge clk_sys_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      foc_data_q  <= '0;
      foc_valid_q <= '0;
      timer_q     <= '0;
    end else begin
      foc_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            target_q                         <= fifo_ch_q[rd_ptr_q];
            foc_data_q                       <= fifo_data_q[rd_ptr_q];
            foc_valid_q[fifo_ch_q[rd_ptr_q]] <= 1'b1;
            timer_q                          <= TW'(TIMEOUT_CYCLES);
            state_q                          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_tgt || tmo_evt) state_q <= S_IDLE;
          else                     timer_q <= timer_q - TW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky status; a same-cycle set beats a status clear.
  always_ff @(posedge clk_sys_i or negedge rstb_i) begin
    if (!rstb_i) status_q <= '0;
    else         status_q <= (is_clrst ? 3'b000 : status_q) | {tmo_evt, bad_evt, ovf_evt};
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_cfg_out
    assign kpd_o[c*D_WIDTH +: D_WIDTH]  = kpd_q[c];
    assign kpq_o[c*D_WIDTH +: D_WIDTH]  = kpq_q[c];
    assign kid_o[c*D_WIDTH +: D_WIDTH]  = kid_q[c];
    assign kiq_o[c*D_WIDTH +: D_WIDTH]  = kiq_q[c];
    assign ptop_o[c*D_WIDTH +: D_WIDTH] = ptop_q[c];
  end

  assign clear_pid_o  = clear_pid_q;
  assign foc_data_o   = foc_data_q;
  assign foc_valid_o  = foc_valid_q;
  assign ready_o      = ready_q;
  assign busy_o       = (state_q == S_WAIT);
  assign fifo_count_o = count_q;
  assign status_o     = status_q;

endmodule

// File: tb/tb_foc_cmd_dispatch.sv
// Directed bench for foc_cmd_dispatch (N_CH=2, FIFO_DEPTH=4, timeout 16).
module tb_foc_cmd_dispatch;

  localparam int DW = 80;

  logic          clk_sys = 1'b0;
  logic          rstb = 1'b1;
  logic          frm_valid = 1'b0;
  logic [7:0]    frm_opcode = '0;
  logic [DW-1:0] frm_data = '0;
  logic [31:0]   kpd, kpq, kid, kiq, ptop;
  logic [1:0]    clear_pid, foc_valid, foc_done;
  logic [DW-1:0] foc_data;
  logic          ready, busy;
  logic [2:0]    fifo_count, status;

  int checks = 0;
  int errors = 0;

  foc_cmd_dispatch #(
    .D_WIDTH(16), .N_WORDS(5), .N_CH(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_sys_i(clk_sys), .rstb_i(rstb),
    .frm_valid_i(frm_valid), .frm_opcode_i(frm_opcode), .frm_data_i(frm_data),
    .kpd_o(kpd), .kpq_o(kpq), .kid_o(kid), .kiq_o(kiq), .ptop_o(ptop),
    .clear_pid_o(clear_pid), .foc_data_o(foc_data), .foc_valid_o(foc_valid),
    .foc_done_i(foc_done), .ready_o(ready), .busy_o(busy),
    .fifo_count_o(fifo_count), .status_o(status)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [DW-1:0] mk(input logic [15:0] w4, w3, w2, w1, w0);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [DW-1:0] d);
    frm_valid  = 1'b1;
    frm_opcode = op;
    frm_data   = d;
    tick();
    frm_valid  = 1'b0;
    frm_data   = '0;
  endtask

  task automatic pulse_done(input logic [1:0] d);
    foc_done = d;
    tick();
    foc_done = '0;
  endtask

  task automatic clr_status();
    send(8'h20, '0);
    tick();
    checks++;
    if (status !== 3'b000) begin
      errors++;
      $display("FAIL clr_status: got %b want 000", status);
    end
  endtask

  task automatic test_reset();
    foc_done = '0;
    #2 rstb = 1'b0;
    #20;
    checks++;
    if ({kpd, kpq, kid, kiq, ptop} !== '0 || clear_pid !== 2'b00 || foc_valid !== 2'b00 ||
        foc_data !== '0 || busy !== 1'b0 || ready !== 1'b1 || fifo_count !== 3'd0 ||
        status !== 3'b000) begin
      errors++;
      $display("FAIL reset: busy=%b ready=%b cnt=%0d status=%b valid=%b clr=%b want 0 1 0 000 00 00",
               busy, ready, fifo_count, status, foc_valid, clear_pid);
    end
    @(posedge clk_sys);
    #1 rstb = 1'b1;
    tick();
  endtask

  task automatic test_load();
    send(8'h01, mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0800));
    checks++;
    if (kpd !== 32'h0) begin
      errors++;
      $display("FAIL load_latency: kpd=%h want 00000000", kpd);
    end
    tick();
    checks++;
    if (kpd !== 32'h1111_0000 || kpq !== 32'h2222_0000 || kid !== 32'h3333_0000 ||
        kiq !== 32'h4444_0000 || ptop !== 32'h0800_0000) begin
      errors++;
      $display("FAIL load_gains: kpd=%h kpq=%h kid=%h kiq=%h ptop=%h want 11110000 22220000 33330000 44440000 08000000",
               kpd, kpq, kid, kiq, ptop);
    end
    checks++;
    if (clear_pid !== 2'b10) begin
      errors++;
      $display("FAIL load_clear_pid: got %b want 10", clear_pid);
    end
    tick();
    checks++;
    if (clear_pid !== 2'b00) begin
      errors++;
      $display("FAIL load_clear_pulse_len: got %b want 00", clear_pid);
    end
    send(8'h10, mk(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA));
    tick();
    checks++;
    if (clear_pid !== 2'b01 || kpd !== 32'h1111_0000 || ptop !== 32'h0800_0000) begin
      errors++;
      $display("FAIL clear_cmd: clr=%b kpd=%h ptop=%h want 01 11110000 08000000", clear_pid, kpd, ptop);
    end
    tick();
  endtask

  task automatic test_back_to_back_overflow();
    logic [DW-1:0] f [6];
    for (int i = 0; i < 6; i++)
      f[i] = mk(16'(16'hA000 + i), 16'(16'hB000 + i), 16'(16'hC000 + i), 16'(16'hD000 + i), 16'(16'hE000 + i));
    for (int i = 0; i < 6; i++) begin
      send(8'hF0, f[i]);
      if (i == 2) begin
        checks++;
        if (foc_valid !== 2'b01 || foc_data !== f[0] || busy !== 1'b1) begin
          errors++;
          $display("FAIL first_dispatch: valid=%b busy=%b data=%h want 01 1 %h", foc_valid, busy, foc_data, f[0]);
        end
      end
    end
    tick();
    checks++;
    if (fifo_count !== 3'd4 || ready !== 1'b0 || status !== 3'b001) begin
      errors++;
      $display("FAIL overflow: cnt=%0d ready=%b status=%b want 4 0 001", fifo_count, ready, status);
    end
    for (int k = 1; k < 5; k++) begin
      pulse_done(2'b01);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_to_idle[%0d]: busy=%b want 0", k, busy);
      end
      tick();
      checks++;
      if (foc_valid !== 2'b01 || foc_data !== f[k] || fifo_count !== 3'(4 - k) || ready !== 1'b1) begin
        errors++;
        $display("FAIL in_order[%0d]: valid=%b cnt=%0d ready=%b data=%h want 01 %0d 1 %h",
                 k, foc_valid, fifo_count, ready, foc_data, 4 - k, f[k]);
      end
    end
    pulse_done(2'b01);
    tick();
    checks++;
    if (busy !== 1'b0 || foc_valid !== 2'b00 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain: busy=%b valid=%b cnt=%0d want 0 00 0", busy, foc_valid, fifo_count);
    end
    clr_status();
  endtask

  task automatic test_channel_select();
    logic [DW-1:0] g;
    g = mk(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505);
    send(8'hF1, g);
    tick();
    tick();
    checks++;
    if (foc_valid !== 2'b10 || foc_data !== g || busy !== 1'b1) begin
      errors++;
      $display("FAIL ch1_dispatch: valid=%b busy=%b data=%h want 10 1 %h", foc_valid, busy, foc_data, g);
    end
    pulse_done(2'b01);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wrong_done_ignored: busy=%b want 1", busy);
    end
    pulse_done(2'b10);
    checks++;
    if (busy !== 1'b0 || foc_data !== g) begin
      errors++;
      $display("FAIL ch1_done: busy=%b data=%h want 0 %h", busy, foc_data, g);
    end
    tick();
  endtask

  task automatic test_timeout();
    send(8'hF0, mk(16'h1, 16'h2, 16'h3, 16'h4, 16'h5));
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (busy !== 1'b1 || status !== 3'b000) begin
      errors++;
      $display("FAIL timeout_early: busy=%b status=%b want 1 000", busy, status);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || status !== 3'b100) begin
      errors++;
      $display("FAIL timeout: busy=%b status=%b want 0 100", busy, status);
    end
    clr_status();
  endtask

  task automatic test_bad_opcode();
    send(8'h05, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    tick();
    checks++;
    if (status !== 3'b010 || kpd !== 32'h1111_0000 || ptop !== 32'h0800_0000 ||
        fifo_count !== 3'd0 || clear_pid !== 2'b00) begin
      errors++;
      $display("FAIL bad_channel: status=%b kpd=%h ptop=%h cnt=%0d clr=%b want 010 11110000 08000000 0 00",
               status, kpd, ptop, fifo_count, clear_pid);
    end
    clr_status();
    send(8'h70, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    tick();
    checks++;
    if (status !== 3'b010 || kiq !== 32'h4444_0000 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode: status=%b kiq=%h cnt=%0d busy=%b want 010 44440000 0 0",
               status, kiq, fifo_count, busy);
    end
    clr_status();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    send(8'hF0, mk(16'h9, 16'h9, 16'h9, 16'h9, 16'h9));
    send(8'hF0, mk(16'h8, 16'h8, 16'h8, 16'h8, 16'h8));
    tick();
    tick();
    rstb = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0 || foc_valid !== 2'b00 || kpd !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: busy=%b cnt=%0d valid=%b kpd=%h want 0 0 00 0", busy, fifo_count, foc_valid, kpd);
    end
    @(posedge clk_sys);
    #1 rstb = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (foc_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_issue_after_reset: %0d cycles with activity want 0", seen);
    end
  endtask

  initial begin
    foc_done = '0;
    test_reset();
    test_load();
    test_back_to_back_overflow();
    test_channel_select();
    test_timeout();
    test_bad_opcode();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
